// File: rtl/rr_dec_arbiter_pkg.sv
// Shared constants and helpers for the round-robin decoder arbiter.
package rr_dec_pkg;

  localparam int NREQ = 4;

  // Arbiter FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Rotate-priority find-first: returns the first set bit of req when
  // scanning ptr, ptr+1, ... modulo 4. Returns ptr when req is empty
  // (callers only use the result when req != 0).
  function automatic logic [1:0] rr_next(input logic [NREQ-1:0] req,
                                         input logic [1:0]      ptr);
    logic [1:0] win;
    logic [1:0] cand;
    win = ptr;
    // Scan from the farthest offset down so the nearest hit wins last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        win = cand;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between the agents and the arbiter.
//
// Signalling: REQ is a level per agent, held high for as long as the agent
// wants the resource; it is its own "valid" and is only dropped by the agent.
// The arbiter answers with G_L low plus index {B,A}; this acts as "ready"
// for exactly the agent whose REQ bit matches {B,A}. DONE is a one-cycle
// release strobe from the granted agent and is ignored when no grant is
// active. Y_L is the one-cold active-low decode of {G_L,B,A}. BUSY covers
// the grant and the one-cycle break gap; TIMEOUT pulses once after a forced
// release.
interface rr_dec_arbiter_if;
  import rr_dec_pkg::*;

  logic [NREQ-1:0] REQ;
  logic            DONE;
  logic            G_L;
  logic            A;
  logic            B;
  logic [3:0]      Y_L;
  logic            BUSY;
  logic            TIMEOUT;

  // Agent side drives requests and release.
  modport master (
    output REQ, DONE,
    input  G_L, A, B, Y_L, BUSY, TIMEOUT
  );

  // Arbiter side.
  modport slave (
    input  REQ, DONE,
    output G_L, A, B, Y_L, BUSY, TIMEOUT
  );

endinterface

// File: rtl/rr_dec_arbiter_dec2to4_l.sv
// Active-low enable 2-to-4 decoder with one-cold active-low outputs.
module dec2to4_l (
  input  logic       g_l,
  input  logic       a,
  input  logic       b,
  output logic [3:0] y_l
);

  // Pure decode: all high while disabled, else only Y_L[{b,a}] low.
  always_comb begin
    y_l = 4'b1111;
    if (!g_l) begin
      case ({b, a})
        2'd0:    y_l = 4'b1110;
        2'd1:    y_l = 4'b1101;
        2'd2:    y_l = 4'b1011;
        default: y_l = 4'b0111;
      endcase
    end
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Four-requester round-robin arbiter driving one half of a dual 2-to-4
// active-low decoder. Grants are held until DONE, request drop or the
// MAX_HOLD limit, and every release is followed by a one-cycle gap.
module rr_dec_arbiter
  import rr_dec_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  rr_dec_arbiter_if.slave   bus,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_ptr
);

  // Last hold count value before a forced release.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [1:0]        state, state_n;
  logic [1:0]        ptr, ptr_n;
  logic [1:0]        idx, idx_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              timeout_q, timeout_n;
  logic              g_l;
  logic              busy;
  logic              hit_limit;
  logic              release_now;

  assign hit_limit   = (hold_cnt == HOLD_LAST);
  assign release_now = bus.DONE || !bus.REQ[idx] || hit_limit;

  // State register: FSM state, priority pointer, winner index, hold count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      idx       <= 2'd0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      idx       <= idx_n;
      hold_cnt  <= hold_cnt_n;
      timeout_q <= timeout_n;
    end
  end

  // Next-state logic: arbitrate in IDLE, watch release causes in GRANT.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    idx_n      = idx;
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.REQ != '0) begin
          idx_n      = rr_next(bus.REQ, ptr);
          hold_cnt_n = '0;
          state_n    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        hold_cnt_n = hold_cnt + 1'b1;
        if (release_now) begin
          state_n   = ST_GAP;
          ptr_n     = idx + 2'd1;
          // Only a pure limit expiry counts as a timeout.
          timeout_n = hit_limit && !bus.DONE && bus.REQ[idx];
        end
      end
      ST_GAP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output logic: enable low only in GRANT, BUSY across GRANT and GAP.
  always_comb begin
    g_l  = (state != ST_GRANT);
    busy = (state == ST_GRANT) || (state == ST_GAP);
  end

  dec2to4_l u_dec (
    .g_l (g_l),
    .a   (idx[0]),
    .b   (idx[1]),
    .y_l (bus.Y_L)
  );

  assign bus.G_L     = g_l;
  assign bus.A       = idx[0];
  assign bus.B       = idx[1];
  assign bus.BUSY    = busy;
  assign bus.TIMEOUT = timeout_q;
  assign dbg_state   = state;
  assign dbg_ptr     = ptr;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed testbench for rr_dec_arbiter with hand-computed expectations.
module tb_rr_dec_arbiter;
  import rr_dec_pkg::*;

  logic       CLK;
  logic       RESET;
  logic [1:0] dbg_state;
  logic [1:0] dbg_ptr;
  int         n_tests;
  int         n_fail;

  rr_dec_arbiter_if bus ();

  rr_dec_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock and reset.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check the full visible grant state in one call.
  task automatic check_grant(input string tag, input logic [1:0] exp_idx);
    logic [3:0] exp_y;
    exp_y = 4'b1111;
    exp_y[exp_idx] = 1'b0;
    check({tag, "_g_l"},  32'(bus.G_L), 32'd0);
    check({tag, "_idx"},  32'({bus.B, bus.A}), 32'(exp_idx));
    check({tag, "_y_l"},  32'(bus.Y_L), 32'(exp_y));
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
  endtask

  task automatic check_idle_out(input string tag, input logic [1:0] exp_st,
                                input logic exp_busy);
    check({tag, "_state"}, 32'(dbg_state), 32'(exp_st));
    check({tag, "_g_l"},   32'(bus.G_L), 32'd1);
    check({tag, "_y_l"},   32'(bus.Y_L), 32'hF);
    check({tag, "_busy"},  32'(bus.BUSY), 32'(exp_busy));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    RESET    = 1'b1;
    bus.REQ  = 4'b0000;
    bus.DONE = 1'b0;

    // Reset state.
    do_reset();
    check_idle_out("rst", ST_IDLE, 1'b0);
    check("rst_idx", 32'({bus.B, bus.A}), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    check("rst_to",  32'(bus.TIMEOUT), 32'd0);

    // Single requester, release by dropping REQ.
    bus.REQ = 4'b0100;
    tick();
    check_grant("t1", 2'd2);
    bus.REQ = 4'b0000;
    tick();
    check_idle_out("t1_gap", ST_GAP, 1'b1);
    check("t1_keep_idx", 32'({bus.B, bus.A}), 32'd2);
    check("t1_ptr", 32'(dbg_ptr), 32'd3);
    check("t1_to",  32'(bus.TIMEOUT), 32'd0);
    tick();
    check_idle_out("t1_idle", ST_IDLE, 1'b0);

    // Fairness: all four held, DONE in the first cycle of each grant.
    do_reset();
    bus.REQ = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_grant($sformatf("rr%0d", k), 2'(k % 4));
      bus.DONE = 1'b1;
      tick();
      bus.DONE = 1'b0;
      check_idle_out($sformatf("rr%0d_gap", k), ST_GAP, 1'b1);
      tick();
      check_idle_out($sformatf("rr%0d_idle", k), ST_IDLE, 1'b0);
      tick();
    end
    bus.REQ = 4'b0000;
    do_reset();

    // Timeout: agent 1 holds for exactly MAX_HOLD=8 cycles.
    bus.REQ = 4'b0010;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_hold%0d_y", i), 32'(bus.Y_L), 32'hD);
      check($sformatf("to_hold%0d_to", i), 32'(bus.TIMEOUT), 32'd0);
      tick();
    end
    check_idle_out("to_gap", ST_GAP, 1'b1);
    check("to_pulse", 32'(bus.TIMEOUT), 32'd1);
    tick();
    check("to_pulse_end", 32'(bus.TIMEOUT), 32'd0);
    check("to_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    check_grant("to_regrant", 2'd1);
    bus.REQ = 4'b0000;
    do_reset();

    // Reset in the middle of a grant to agent 3.
    bus.REQ = 4'b1000;
    tick();
    check_grant("mr_pre", 2'd3);
    RESET = 1'b1;
    tick();
    check_idle_out("mr_rst", ST_IDLE, 1'b0);
    check("mr_ptr", 32'(dbg_ptr), 32'd0);
    RESET   = 1'b0;
    bus.REQ = 4'b1001;
    tick();
    check_grant("mr_post", 2'd0);
    bus.REQ = 4'b0000;
    do_reset();

    // DONE with new requests during grant of agent 1; other bits ignored.
    bus.REQ = 4'b0010;
    tick();
    check_grant("sim_pre", 2'd1);
    bus.REQ = 4'b0011;
    tick();
    check_grant("sim_other", 2'd1);
    bus.DONE = 1'b1;
    bus.REQ  = 4'b0101;
    tick();
    bus.DONE = 1'b0;
    check_idle_out("sim_gap", ST_GAP, 1'b1);
    check("sim_to", 32'(bus.TIMEOUT), 32'd0);
    check("sim_ptr", 32'(dbg_ptr), 32'd2);
    tick();
    check_idle_out("sim_idle", ST_IDLE, 1'b0);
    tick();
    check_grant("sim_win", 2'd2);
    bus.REQ = 4'b0000;
    do_reset();

    // DONE while idle with no requests is ignored.
    bus.DONE = 1'b1;
    tick();
    check_idle_out("idle_done", ST_IDLE, 1'b0);
    check("idle_done_to", 32'(bus.TIMEOUT), 32'd0);
    tick();
    check_idle_out("idle_done2", ST_IDLE, 1'b0);
    bus.DONE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
